// File: rtl/chroma_upsample_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : chroma_upsample_stream_if
// Description : Block-in / beat-out handshake bundle for the chroma
//               upsampler. The master side is the producer of input blocks and
//               consumer of output beats; the slave side is the upsampler.
// Revision    : 1.0 - initial release
// ============================================================================
interface chroma_upsample_stream_if #(
  parameter int PIX_W = 9,
  parameter int CH_W  = 2
);

  // Input block handshake
  logic                          valid_in;
  logic                          ready_in;
  logic [CH_W-1:0]               ch_in;
  logic [1:0]                    mode_in;
  logic [7:0][7:0][PIX_W-1:0]    block_in;

  // Output beat handshake
  logic                          valid_out;
  logic                          ready_out;
  logic [7:0][7:0][PIX_W-1:0]    block_out;
  logic [CH_W-1:0]               ch_out;
  logic [1:0]                    quad_out;
  logic                          last_out;
  logic                          err_out;

  modport master (
    output valid_in, ch_in, mode_in, block_in, ready_out,
    input  ready_in, valid_out, block_out, ch_out, quad_out, last_out, err_out
  );

  modport slave (
    input  valid_in, ch_in, mode_in, block_in, ready_out,
    output ready_in, valid_out, block_out, ch_out, quad_out, last_out, err_out
  );

endinterface
`default_nettype wire

// File: rtl/chroma_upsample_stream.sv
`default_nettype none
// ============================================================================
// Module      : chroma_upsample_stream
// Description : Accepts one 8x8 block per handshake and emits it as 1, 2 or 4
//               upsampled 8x8 beats (4:4:4 / 4:2:2 / 4:2:0) by pixel
//               replication, under valid/ready backpressure.
//               Optional macro SUPSAMP_PERF_CNT_EN adds the accepted-block and
//               output-stall counters blk_cnt_out / stall_cnt_out.
// Revision    : 1.0 - initial release
// ============================================================================
module chroma_upsample_stream #(
  parameter int PIX_W = 9,
  parameter int CH_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  chroma_upsample_stream_if.slave     bus
`ifdef SUPSAMP_PERF_CNT_EN
  ,
  output logic [31:0]                 blk_cnt_out,
  output logic [31:0]                 stall_cnt_out
`endif
);

  // Channel tags
  localparam logic [CH_W-1:0] C_CH_Y  = CH_W'(0);
  localparam logic [CH_W-1:0] C_CH_CR = CH_W'(2);

  // Replication kinds held alongside the block
  localparam logic [1:0] C_KIND_COPY  = 2'd0;
  localparam logic [1:0] C_KIND_HORIZ = 2'd1;
  localparam logic [1:0] C_KIND_BOTH  = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                       r_state;
  logic [7:0][7:0][PIX_W-1:0]   r_pix;
  logic [CH_W-1:0]              r_ch;
  logic [1:0]                   r_kind;
  logic [1:0]                   r_beat;
  logic [1:0]                   r_last_beat;
  logic                         r_err;

  logic                         w_out_fire;
  logic                         w_on_last;
  logic                         w_accept;
  logic                         w_illegal;
  logic [1:0]                   w_kind;
  logic [1:0]                   w_last_idx;
  logic [7:0][7:0][PIX_W-1:0]   w_block;

  // Handshake terms; ready_in is forced low for as long as rst is held
  assign w_out_fire   = (r_state == EMIT) && bus.ready_out;
  assign w_on_last    = (r_beat == r_last_beat);
  assign bus.ready_in = !rst && ((r_state == IDLE) || (w_out_fire && w_on_last));
  assign w_accept     = bus.valid_in && bus.ready_in;

  // Unknown tags are illegal; reserved mode is illegal only for chroma
  assign w_illegal = (bus.ch_in > C_CH_CR) ||
                     ((bus.ch_in != C_CH_Y) && (bus.mode_in == 2'd3));

  // Decode replication kind and final beat index; luma is never upsampled
  always_comb begin
    w_kind     = C_KIND_COPY;
    w_last_idx = 2'd0;
    if (bus.ch_in != C_CH_Y) begin
      case (bus.mode_in)
        2'd1: begin
          w_kind     = C_KIND_HORIZ;
          w_last_idx = 2'd1;
        end
        2'd2: begin
          w_kind     = C_KIND_BOTH;
          w_last_idx = 2'd3;
        end
        default: begin
          w_kind     = C_KIND_COPY;
          w_last_idx = 2'd0;
        end
      endcase
    end
  end

  // Control FSM plus block/tag capture; illegal blocks are swallowed and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pix       <= '0;
      r_ch        <= '0;
      r_kind      <= C_KIND_COPY;
      r_beat      <= 2'd0;
      r_last_beat <= 2'd0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_beat <= 2'd0;
        if (w_illegal) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_state     <= EMIT;
          r_pix       <= bus.block_in;
          r_ch        <= bus.ch_in;
          r_kind      <= w_kind;
          r_last_beat <= w_last_idx;
        end
      end else if (w_out_fire) begin
        if (w_on_last) begin
          r_state <= IDLE;
          r_beat  <= 2'd0;
        end else begin
          r_beat <= r_beat + 2'd1;
        end
      end
    end
  end

  // Replicate the selected quadrant of the held block; quadrant row comes
  // from beat bit 1 and quadrant column from beat bit 0
  always_comb begin
    logic [2:0] v_row;
    logic [2:0] v_col;
    w_block = '0;
    v_row   = 3'd0;
    v_col   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        v_row = 3'(i);
        v_col = 3'(j);
        if (r_kind == C_KIND_BOTH) begin
          v_row = {r_beat[1], 2'(i / 2)};
        end
        if (r_kind != C_KIND_COPY) begin
          v_col = {r_beat[0], 2'(j / 2)};
        end
        w_block[i][j] = r_pix[v_row][v_col];
      end
    end
  end

  assign bus.valid_out = (r_state == EMIT);
  assign bus.block_out = w_block;
  assign bus.ch_out    = r_ch;
  assign bus.quad_out  = r_beat;
  assign bus.last_out  = (r_state == EMIT) && w_on_last;
  assign bus.err_out   = r_err;

`ifdef SUPSAMP_PERF_CNT_EN
  logic [31:0] r_blk_cnt;
  logic [31:0] r_stall_cnt;

  // Free-running wrap-around counters for accepted blocks and stalled beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_cnt   <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_accept) begin
        r_blk_cnt <= r_blk_cnt + 32'd1;
      end
      if ((r_state == EMIT) && !bus.ready_out) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign blk_cnt_out   = r_blk_cnt;
  assign stall_cnt_out = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chroma_upsample_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_chroma_upsample_stream
// Description : Scoreboard bench for chroma_upsample_stream. Stimulus pushes
//               expected beats (with hand-computed spot pixels); a negedge
//               monitor compares every presented beat against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chroma_upsample_stream;

  typedef logic [7:0][7:0][8:0] pix_t;

  typedef struct {
    pix_t       blk;
    logic [1:0] ch;
    logic [1:0] quad;
    logic       last;
    int         si;
    int         sj;
    int         sv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   err_pulses = 0;
  exp_t sb[$];

  chroma_upsample_stream_if #(.PIX_W(9), .CH_W(2)) bus ();

`ifdef SUPSAMP_PERF_CNT_EN
  logic [31:0] blk_cnt;
  logic [31:0] stall_cnt;
`endif

  chroma_upsample_stream #(.PIX_W(9), .CH_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave)
`ifdef SUPSAMP_PERF_CNT_EN
    ,
    .blk_cnt_out   (blk_cnt),
    .stall_cnt_out (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input pix_t act, input pix_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic pix_t pat_a();
    pix_t p;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        p[i][j] = 9'(8 * i + j);
    return p;
  endfunction

  function automatic pix_t pat_b();
    pix_t p;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        p[i][j] = 9'(511 - (8 * i + j));
    return p;
  endfunction

  // Reference replication straight from the index formulas
  function automatic pix_t expand(input pix_t src, input int kind, input int q);
    pix_t o;
    int r = q / 2;
    int c = q % 2;
    int si;
    int sj;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        si = (kind == 2) ? (4 * r + i / 2) : i;
        sj = (kind != 0) ? (4 * c + j / 2) : j;
        o[i][j] = src[si][sj];
      end
    end
    return o;
  endfunction

  task automatic expect_block(input logic [1:0] ch, input logic [1:0] mode, input pix_t blk);
    int   kind;
    int   nb;
    exp_t e;
    if (ch == 2'd3 || (ch != 2'd0 && mode == 2'd3)) return;
    kind = (ch == 2'd0) ? 0 : int'(mode);
    nb   = (kind == 2) ? 4 : ((kind == 1) ? 2 : 1);
    for (int q = 0; q < nb; q++) begin
      e.blk  = expand(blk, kind, q);
      e.ch   = ch;
      e.quad = 2'(q);
      e.last = (q == nb - 1);
      e.si   = -1;
      e.sj   = 0;
      e.sv   = 0;
      sb.push_back(e);
    end
  endtask

  task automatic spot(input int idx, input int i, input int j, input int v);
    sb[idx].si = i;
    sb[idx].sj = j;
    sb[idx].sv = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge
  task automatic drive(input logic [1:0] ch, input logic [1:0] mode, input pix_t blk,
                       output int waited);
    bus.valid_in = 1'b1;
    bus.ch_in    = ch;
    bus.mode_in  = mode;
    bus.block_in = blk;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.ready_in) break;
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    step();
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.valid_out) break;
      n++;
      if (n > 100) break;
    end
    chk("drain", 32'(sb.size() == 0 && !bus.valid_out), 32'd1);
    step();
  endtask

  // Scoreboard monitor: every presented beat is compared against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.err_out) err_pulses++;
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          chk_blk("beat_block", bus.block_out, e.blk);
          chk("beat_ch", 32'(bus.ch_out), 32'(e.ch));
          chk("beat_quad", 32'(bus.quad_out), 32'(e.quad));
          chk("beat_last", 32'(bus.last_out), 32'(e.last));
          if (e.si >= 0)
            chk("beat_spot", 32'(bus.block_out[e.si][e.sj]), 32'(e.sv));
          if (bus.ready_out) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.ch_in     = 2'd0;
    bus.mode_in   = 2'd0;
    bus.block_in  = '0;
    bus.ready_out = 1'b1;

    // Reset state
    step();
    chk("rst_ready_in", 32'(bus.ready_in), 32'd0);
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk_blk("rst_block_out", bus.block_out, '0);
    chk("rst_ch_quad_last_err",
        32'({bus.ch_out, bus.quad_out, bus.last_out, bus.err_out}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_in", 32'(bus.ready_in), 32'd1);
    step();

    // Luma, mode field ignored: one verbatim beat, latency 1
    expect_block(2'd0, 2'd2, pat_a());
    spot(0, 3, 5, 29);
    drive(2'd0, 2'd2, pat_a(), w);
    @(negedge clk);
    chk("y_latency_valid", 32'(bus.valid_out), 32'd1);
    wait_drain();

    // Cb 4:2:0: four quadrants
    expect_block(2'd1, 2'd2, pat_a());
    spot(1, 0, 0, 4);
    spot(2, 0, 0, 32);
    spot(3, 0, 0, 36);
    drive(2'd1, 2'd2, pat_a(), w);
    wait_drain();

    // Cr 4:2:2: two horizontal halves
    expect_block(2'd2, 2'd1, pat_a());
    spot(0, 2, 3, 17);
    spot(1, 5, 6, 47);
    drive(2'd2, 2'd1, pat_a(), w);
    wait_drain();

    // Back-to-back Cb 4:2:0 then Y with valid_in held high
    expect_block(2'd1, 2'd2, pat_b());
    expect_block(2'd0, 2'd0, pat_b());
    spot(2, 1, 1, 479);
    spot(4, 7, 7, 448);
    drive(2'd1, 2'd2, pat_b(), w);
    drive(2'd0, 2'd0, pat_b(), w);
    chk("b2b_ready_wait", 32'(w), 32'd3);
    @(negedge clk);
    chk("b2b_no_bubble", 32'(bus.valid_out), 32'd1);
    wait_drain();

    // Backpressure: ready_out 1,0,0,1 across the first beats
    expect_block(2'd1, 2'd2, pat_a());
    spot(1, 3, 2, 13);
    spot(3, 7, 7, 63);
    drive(2'd1, 2'd2, pat_a(), w);
    step();
    bus.ready_out = 1'b0;
    @(negedge clk);
    chk("bp_stall_quad", 32'(bus.quad_out), 32'd1);
    step();
    bus.ready_out = 1'b0;
    step();
    bus.ready_out = 1'b1;
    wait_drain();

    // Illegal tag, then reserved mode on chroma
    drive(2'd3, 2'd0, pat_a(), w);
    @(negedge clk);
    chk("ill_tag_err", 32'(bus.err_out), 32'd1);
    chk("ill_tag_novalid", 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    chk("ill_tag_err_clear", 32'(bus.err_out), 32'd0);
    step();
    drive(2'd1, 2'd3, pat_a(), w);
    @(negedge clk);
    chk("ill_mode_err", 32'(bus.err_out), 32'd1);
    chk("ill_mode_novalid", 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    chk("ill_mode_err_clear", 32'(bus.err_out), 32'd0);
    chk("ill_mode_novalid2", 32'(bus.valid_out), 32'd0);
    step();
    chk("err_pulse_count", 32'(err_pulses), 32'd2);

`ifdef SUPSAMP_PERF_CNT_EN
    chk("perf_blk_cnt", blk_cnt, 32'd8);
    chk("perf_stall_cnt", stall_cnt, 32'd2);
`endif

    // Reset in the middle of a stalled 4:2:0 block
    expect_block(2'd1, 2'd2, pat_b());
    bus.ready_out = 1'b0;
    drive(2'd1, 2'd2, pat_b(), w);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.valid_out), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk_blk("mid_rst_block_out", bus.block_out, '0);
    chk("mid_rst_ready_in", 32'(bus.ready_in), 32'd0);
    chk("mid_rst_ch_quad_last",
        32'({bus.ch_out, bus.quad_out, bus.last_out}), 32'd0);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    bus.ready_out = 1'b1;
    #1;
    chk("after_rst_ready_in", 32'(bus.ready_in), 32'd1);
    @(negedge clk);
    chk("after_rst_no_beats", 32'(bus.valid_out), 32'd0);
`ifdef SUPSAMP_PERF_CNT_EN
    chk("perf_blk_cnt_rst", blk_cnt, 32'd0);
    chk("perf_stall_cnt_rst", stall_cnt, 32'd0);
`endif
    step();
    step();
    chk("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
